pipe_ctrl: RTL and testbench

- Pipeline control unit. Turns stall requests from the ID stage (load-use) and the EX stage (multi-cycle ops) into the per-stage stall vector for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Adds a debug halt/single-step sequencer. A halt drains in-flight instructions before the pipeline freezes.
- Keeps a run-mode stall-cycle performance counter and a stuck-stall watchdog.

---
 rtl/pipe_ctrl.sv | 152 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline stall controller: per-stage stall vector, debug halt/step sequencer,
// stall-cycle performance counter and stuck-stall watchdog.
module pipe_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned TO_W         = 8,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             dbg_halt_req,
    input  logic             dbg_step,
    output logic [5:0]       stall_o,
    output logic             halted_o,
    output logic             step_done_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             timeout_o
);

    localparam int unsigned DC_W = 4;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2,
        S_STEP   = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [DC_W-1:0]   drain_q, drain_d;
    logic              step_done_q, step_done_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TO_W-1:0]   wd_q, wd_d;
    logic              timeout_q, timeout_d;
    logic [5:0]        p_stall_c;
    logic [5:0]        stall_c;
    logic              advance_c;
    logic              req_any_c;

    // EX requests freeze one stage deeper than ID and take priority
    always_comb begin
        p_stall_c = 6'b000000;
        if (stallreq_ex) begin
            p_stall_c = 6'b001111;
        end else if (stallreq_id) begin
            p_stall_c = 6'b000111;
        end
    end

    assign advance_c = (p_stall_c == 6'b000000);
    assign req_any_c = stallreq_id | stallreq_ex;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        step_done_d = 1'b0;
        case (state_q)
            S_RUN: begin
                if (dbg_halt_req) begin
                    state_d = S_DRAIN;
                    drain_d = DC_W'(DRAIN_CYCLES - 1);
                end
            end
            S_DRAIN: begin
                if (!dbg_halt_req) begin
                    state_d = S_RUN;
                end else if (advance_c) begin
                    if (drain_q == '0) begin
                        state_d = S_HALTED;
                    end else begin
                        drain_d = drain_q - DC_W'(1);
                    end
                end
            end
            S_HALTED: begin
                if (!dbg_halt_req) begin
                    state_d = S_RUN;
                end else if (dbg_step) begin
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                if (!dbg_halt_req) begin
                    state_d = S_RUN;
                end else if (advance_c) begin
                    state_d     = S_HALTED;
                    step_done_d = 1'b1;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    // Drain freezes only the front end so in-flight instructions retire
    always_comb begin
        stall_c = p_stall_c;
        case (state_q)
            S_DRAIN:  stall_c = p_stall_c | 6'b000011;
            S_HALTED: stall_c = 6'b111111;
            default:  stall_c = p_stall_c;
        endcase
    end

    assign stall_o  = rst ? 6'b000000 : stall_c;
    assign halted_o = (state_q == S_HALTED);

    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == S_RUN) && stall_c[0] && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        wd_d = wd_q;
        if (state_q != S_HALTED) begin
            if (!req_any_c) begin
                wd_d = '0;
            end else if (wd_q != {TO_W{1'b1}}) begin
                wd_d = wd_q + TO_W'(1);
            end
        end
        timeout_d = timeout_q | (wd_d == {TO_W{1'b1}});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_q     <= '0;
            step_done_q <= 1'b0;
            cnt_q       <= '0;
            wd_q        <= '0;
            timeout_q   <= 1'b0;
        end else begin
            drain_q     <= drain_d;
            step_done_q <= step_done_d;
            cnt_q       <= cnt_d;
            wd_q        <= wd_d;
            timeout_q   <= timeout_d;
        end
    end

    assign step_done_o = step_done_q;
    assign stall_cnt_o = cnt_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_pipe_ctrl;

    localparam int unsigned DRAIN_CYCLES = 4;
    localparam int unsigned TO_W         = 4;
    localparam int unsigned CNT_W        = 8;
    localparam int          TO_LIMIT     = (1 << TO_W) - 1;
    localparam int          CNT_MAX      = (1 << CNT_W) - 1;

    localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2, M_STEP = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             stallreq_id = 1'b0;
    logic             stallreq_ex = 1'b0;
    logic             dbg_halt_req = 1'b0;
    logic             dbg_step = 1'b0;
    logic [5:0]       stall_o;
    logic             halted_o;
    logic             step_done_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic             timeout_o;

    int total = 0;
    int bad   = 0;

    // reference model state
    int m_mode, m_left, m_cnt, m_run_len;
    bit m_sd, m_to;

    pipe_ctrl #(
        .DRAIN_CYCLES(DRAIN_CYCLES),
        .TO_W        (TO_W),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stallreq_id (stallreq_id),
        .stallreq_ex (stallreq_ex),
        .dbg_halt_req(dbg_halt_req),
        .dbg_step    (dbg_step),
        .stall_o     (stall_o),
        .halted_o    (halted_o),
        .step_done_o (step_done_o),
        .stall_cnt_o (stall_cnt_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [5:0] pterm(input logic id, input logic ex);
        if (ex) return 6'b001111;
        if (id) return 6'b000111;
        return 6'b000000;
    endfunction

    function automatic logic [5:0] model_stall();
        logic [5:0] p;
        p = pterm(stallreq_id, stallreq_ex);
        case (m_mode)
            M_DRAIN: return p | 6'b000011;
            M_HALT:  return 6'b111111;
            default: return p;
        endcase
    endfunction

    function automatic void model_reset();
        m_mode = M_RUN; m_left = 0; m_cnt = 0; m_run_len = 0; m_sd = 0; m_to = 0;
    endfunction

    // advance the model by one clock using the inputs currently applied
    function automatic void model_step();
        logic [5:0] p;
        bit adv, req, sd_next;
        p   = pterm(stallreq_id, stallreq_ex);
        adv = (p == 6'b0);
        req = stallreq_id | stallreq_ex;
        if (m_mode == M_RUN && p[0] && m_cnt < CNT_MAX) m_cnt++;
        if (m_mode != M_HALT) begin
            m_run_len = req ? m_run_len + 1 : 0;
            if (m_run_len >= TO_LIMIT) m_to = 1;
        end
        sd_next = 0;
        case (m_mode)
            M_RUN: if (dbg_halt_req) begin m_mode = M_DRAIN; m_left = DRAIN_CYCLES; end
            M_DRAIN: begin
                if (!dbg_halt_req) m_mode = M_RUN;
                else if (adv) begin
                    m_left--;
                    if (m_left == 0) m_mode = M_HALT;
                end
            end
            M_HALT: begin
                if (!dbg_halt_req) m_mode = M_RUN;
                else if (dbg_step) m_mode = M_STEP;
            end
            default: begin
                if (!dbg_halt_req) m_mode = M_RUN;
                else if (adv) begin m_mode = M_HALT; sd_next = 1; end
            end
        endcase
        m_sd = sd_next;
    endfunction

    // one clock: apply inputs, compare all outputs mid-cycle, then clock both
    task automatic tick(input logic id, input logic ex, input logic halt, input logic step);
        stallreq_id = id; stallreq_ex = ex; dbg_halt_req = halt; dbg_step = step;
        #3;
        chk("stall_o",     32'(stall_o),     32'(model_stall()));
        chk("halted_o",    32'(halted_o),    32'(m_mode == M_HALT));
        chk("step_done_o", 32'(step_done_o), 32'(m_sd));
        chk("stall_cnt_o", 32'(stall_cnt_o), 32'(m_cnt));
        chk("timeout_o",   32'(timeout_o),   32'(m_to));
        model_step();
        @(posedge clk);
        #1;
    endtask

    // assert reset between clock edges and expect immediate clearing
    task automatic async_reset();
        stallreq_ex = 1'b1; stallreq_id = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_stall",   32'(stall_o),     32'h0);
        chk("rst_halted",  32'(halted_o),    32'h0);
        chk("rst_cnt",     32'(stall_cnt_o), 32'h0);
        chk("rst_timeout", 32'(timeout_o),   32'h0);
        chk("rst_sd",      32'(step_done_o), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // idle after reset
        tick(0, 0, 0, 0);
        chk("idle_stall", 32'(stall_o), 32'h0);

        // RUN stalls: ID x3 then EX+ID x2
        repeat (3) tick(1, 0, 0, 0);
        repeat (2) tick(1, 1, 0, 0);
        tick(0, 0, 0, 0);
        chk("cnt_after_run", 32'(stall_cnt_o), 32'd5);

        // halt with drain, EX stall on the second drain cycle
        tick(0, 0, 1, 0);
        tick(0, 0, 1, 0);
        tick(0, 1, 1, 0);
        tick(0, 0, 1, 0);
        tick(0, 0, 1, 0);
        tick(0, 0, 1, 0);
        chk("halted_after_drain", 32'(halted_o), 32'd1);
        chk("halted_stall", 32'(stall_o), 32'h3f);

        // single step, no stall
        tick(0, 0, 1, 1);
        tick(0, 0, 1, 0);
        tick(0, 0, 1, 0);
        tick(0, 0, 1, 0);

        // single step stretched by two ID stall cycles
        tick(0, 0, 1, 1);
        tick(1, 0, 1, 1);
        tick(1, 0, 1, 0);
        tick(0, 0, 1, 0);
        tick(0, 0, 1, 0);
        tick(0, 0, 1, 0);

        // release beats a simultaneous step
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);

        // halt aborted during drain
        tick(0, 0, 1, 0);
        tick(0, 0, 1, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);

        // watchdog: EX held for exactly the limit
        repeat (TO_LIMIT) tick(0, 1, 0, 0);
        chk("timeout_set", 32'(timeout_o), 32'd1);
        repeat (3) tick(0, 0, 0, 0);
        chk("timeout_sticky", 32'(timeout_o), 32'd1);

        // halt then reset mid-halt
        repeat (DRAIN_CYCLES + 2) tick(0, 0, 1, 0);
        async_reset();
        tick(0, 0, 0, 0);

        // random traffic
        begin
            logic halt_lvl;
            halt_lvl = 1'b0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 19) == 0) halt_lvl = ~halt_lvl;
                if ($urandom_range(0, 799) == 0) begin
                    async_reset();
                end else begin
                    tick(logic'($urandom_range(0, 3) == 0),
                         logic'($urandom_range(0, 7) == 0),
                         halt_lvl,
                         logic'($urandom_range(0, 3) == 0));
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
